// File: rtl/r_mux_2to1.sv
// r_mux_2to1: AXI3 R-channel return mux, two slaves onto one master port.
// Arbitration is round-robin and happens once per burst. The grant stays locked
// until the rlast beat has been accepted, so bursts from the two slaves never
// interleave. An idle cycle always separates two bursts.
// Optional feature (compile-time macro R_MUX_OUT_REG_EN): a 2-entry skid
// buffer between the mux and the master port. The buffer breaks the
// combinational path from rready_m to rready_s1/rready_s2.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no owner; slaves held off; picks the next burst owner
// BURST_S1 | slave 1 owns the R path until its rlast beat is accepted
// BURST_S2 | slave 2 owns the R path until its rlast beat is accepted
module r_mux_2to1 #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic [ID_W-1:0]   rid_s1,
    input  logic [DATA_W-1:0] rdata_s1,
    input  logic [1:0]        rresp_s1,
    input  logic              rlast_s1,
    input  logic              rvalid_s1,
    output logic              rready_s1,

    input  logic [ID_W-1:0]   rid_s2,
    input  logic [DATA_W-1:0] rdata_s2,
    input  logic [1:0]        rresp_s2,
    input  logic              rlast_s2,
    input  logic              rvalid_s2,
    output logic              rready_s2,

    output logic [ID_W-1:0]   rid_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic [1:0]        rresp_m,
    output logic              rlast_m,
    output logic              rvalid_m,
    input  logic              rready_m,

    output logic [1:0]        grant
);

    // A beat is packed as {rid, rdata, rresp, rlast}, so bit 0 is rlast.
    localparam int PW = ID_W + DATA_W + 2 + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_S1 = 2'd1,
        BURST_S2 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_srv_q, last_srv_d;   // 0: s1 served last, 1: s2 served last
    logic [1:0]    grant_q, grant_d;

    logic          sel_valid;
    logic [PW-1:0] sel_payload;
    logic          sel_ready;
    logic          beat_acc;
    logic          last_acc;

    // Select the owning slave's beat; nothing is selected while idle.
    always_comb begin
        sel_valid   = 1'b0;
        sel_payload = '0;
        case (state_q)
            BURST_S1: begin
                sel_valid   = rvalid_s1;
                sel_payload = {rid_s1, rdata_s1, rresp_s1, rlast_s1};
            end
            BURST_S2: begin
                sel_valid   = rvalid_s2;
                sel_payload = {rid_s2, rdata_s2, rresp_s2, rlast_s2};
            end
            default: begin
                sel_valid   = 1'b0;
                sel_payload = '0;
            end
        endcase
    end

    // Only the owner sees ready; the other slave is held off for the whole burst.
    always_comb begin
        rready_s1 = (state_q == BURST_S1) && sel_ready;
        rready_s2 = (state_q == BURST_S2) && sel_ready;
        beat_acc  = sel_valid && sel_ready;
        last_acc  = beat_acc && sel_payload[0];
    end

    // Next owner: a lone requester wins; on a tie the slave not served last wins.
    always_comb begin
        state_d    = state_q;
        last_srv_d = last_srv_q;
        grant_d    = grant_q;
        case (state_q)
            IDLE: begin
                if (rvalid_s1 && (!rvalid_s2 || last_srv_q)) begin
                    state_d = BURST_S1;
                    grant_d = 2'b01;
                end else if (rvalid_s2) begin
                    state_d = BURST_S2;
                    grant_d = 2'b10;
                end
            end
            BURST_S1: begin
                if (last_acc) begin
                    state_d    = IDLE;
                    last_srv_d = 1'b0;
                    grant_d    = 2'b00;
                end
            end
            BURST_S2: begin
                if (last_acc) begin
                    state_d    = IDLE;
                    last_srv_d = 1'b1;
                    grant_d    = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Arbiter registers. After reset last_srv is set so that s1 wins the first tie.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            last_srv_q <= 1'b1;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            grant_q    <= grant_d;
        end
    end

    assign grant = grant_q;

`ifdef R_MUX_OUT_REG_EN
    // Two-entry skid buffer. The grant is released when the rlast beat is
    // written into the buffer, not when it leaves on the master port.
    logic [PW-1:0] mem_q [2];
    logic [PW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          push;
    logic          pop;
    logic [PW-1:0] head;

    // Accept a beat whenever a slot is free; drain toward the master on its ready.
    always_comb begin
        sel_ready = (count_q != 2'd2);
        push      = beat_acc;
        rvalid_m  = (count_q != 2'd0);
        pop       = rvalid_m && rready_m;
        head      = rvalid_m ? mem_q[rd_ptr_q] : '0;
        {rid_m, rdata_m, rresp_m, rlast_m} = head;
    end

    // Buffer pointer and occupancy update.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (push) begin
            mem_d[wr_ptr_q] = sel_payload;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    // Buffer storage; reset empties it and clears the stored beats.
    always_ff @(posedge aclk) begin
        if (areset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    // Combinational datapath: the owning slave drives the master port directly.
    always_comb begin
        sel_ready = rready_m;
        rvalid_m  = sel_valid;
        {rid_m, rdata_m, rresp_m, rlast_m} = sel_payload;
    end
`endif

endmodule

// File: tb/tb_r_mux_2to1.sv
// Bench for r_mux_2to1, built without the output skid buffer.
// The bench models each slave as a queue of beats. Each test pushes the beats
// it expects to see on the master port, in the expected order, onto a
// scoreboard queue. Every accepted master beat is popped from that queue and
// compared with it.
module tb_r_mux_2to1;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  rid_s1 = '0, rid_s2 = '0, rid_m;
    logic [31:0] rdata_s1 = '0, rdata_s2 = '0, rdata_m;
    logic [1:0]  rresp_s1 = '0, rresp_s2 = '0, rresp_m;
    logic        rlast_s1 = 1'b0, rlast_s2 = 1'b0, rlast_m;
    logic        rvalid_s1 = 1'b0, rvalid_s2 = 1'b0, rvalid_m;
    logic        rready_s1, rready_s2;
    logic        rready_m = 1'b1;
    logic [1:0]  grant;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t s1_q[$];
    beat_t s2_q[$];
    beat_t sb[$];

    // Values captured at the falling edge of the most recent step.
    logic        sn_rvalid_m, sn_rready_s1, sn_rready_s2, sn_hsm;
    logic [1:0]  sn_grant;
    beat_t       sn_beat;
    logic        stall_prev = 1'b0;
    beat_t       held;

    r_mux_2to1 #(.DATA_W(32), .ID_W(4)) dut (
        .aclk(aclk), .areset(areset),
        .rid_s1(rid_s1), .rdata_s1(rdata_s1), .rresp_s1(rresp_s1), .rlast_s1(rlast_s1),
        .rvalid_s1(rvalid_s1), .rready_s1(rready_s1),
        .rid_s2(rid_s2), .rdata_s2(rdata_s2), .rresp_s2(rresp_s2), .rlast_s2(rlast_s2),
        .rvalid_s2(rvalid_s2), .rready_s2(rready_s2),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .grant(grant)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic apply_slaves();
        if (s1_q.size() != 0) begin
            rvalid_s1 = 1'b1;
            {rid_s1, rdata_s1, rresp_s1, rlast_s1} = s1_q[0];
        end else begin
            rvalid_s1 = 1'b0;
            {rid_s1, rdata_s1, rresp_s1, rlast_s1} = '0;
        end
        if (s2_q.size() != 0) begin
            rvalid_s2 = 1'b1;
            {rid_s2, rdata_s2, rresp_s2, rlast_s2} = s2_q[0];
        end else begin
            rvalid_s2 = 1'b0;
            {rid_s2, rdata_s2, rresp_s2, rlast_s2} = '0;
        end
    endtask

    function automatic beat_t mk_beat(input logic [3:0] id, input logic [31:0] base,
                                      input int i, input int n);
        beat_t b;
        b.id   = id;
        b.data = base + 32'(i);
        b.resp = 2'(i);
        b.last = (i == n - 1);
        return b;
    endfunction

    task automatic load_burst(input int slv, input logic [3:0] id, input logic [31:0] base,
                              input int n);
        for (int i = 0; i < n; i++) begin
            if (slv == 1) s1_q.push_back(mk_beat(id, base, i, n));
            else          s2_q.push_back(mk_beat(id, base, i, n));
        end
    endtask

    task automatic sb_burst(input logic [3:0] id, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk_beat(id, base, i, n));
    endtask

    // One clock. Sample and check at the falling edge, then advance the
    // slave models just after the rising edge.
    task automatic step();
        logic  hs1, hs2;
        beat_t cur, exp_b;
        @(negedge aclk);
        hs1 = rvalid_s1 && rready_s1;
        hs2 = rvalid_s2 && rready_s2;
        cur = {rid_m, rdata_m, rresp_m, rlast_m};
        sn_rvalid_m  = rvalid_m;
        sn_rready_s1 = rready_s1;
        sn_rready_s2 = rready_s2;
        sn_grant     = grant;
        sn_hsm       = rvalid_m && rready_m;
        sn_beat      = cur;
        if (!areset) begin
            n_vec++;
            if ((rready_s1 === 1'b1 && grant !== 2'b01) || (rready_s2 === 1'b1 && grant !== 2'b10)) begin
                n_err++;
                $display("FAIL ready_owner: rready_s1=%b rready_s2=%b with grant=%b, required ready only toward owner",
                         rready_s1, rready_s2, grant);
            end
        end
        if (stall_prev) begin
            n_vec++;
            if (cur !== held) begin
                n_err++;
                $display("FAIL stall_stable: payload %h, required %h held while stalled", cur, held);
            end
        end
        if (sn_hsm === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got %h, required no beat", cur);
            end else begin
                exp_b = sb.pop_front();
                if (cur !== exp_b) begin
                    n_err++;
                    $display("FAIL beat: got id=%h data=%h resp=%h last=%b, required id=%h data=%h resp=%h last=%b",
                             cur.id, cur.data, cur.resp, cur.last,
                             exp_b.id, exp_b.data, exp_b.resp, exp_b.last);
                end
            end
        end
        stall_prev = (rvalid_m === 1'b1) && (rready_m === 1'b0);
        held       = cur;
        @(posedge aclk);
        #1;
        if (hs1 === 1'b1) void'(s1_q.pop_front());
        if (hs2 === 1'b1) void'(s2_q.pop_front());
        apply_slaves();
    endtask

    task automatic drain(input string name, input int max_cyc);
        int cyc = 0;
        while ((sb.size() != 0 || s1_q.size() != 0 || s2_q.size() != 0) && cyc < max_cyc) begin
            step();
            cyc++;
        end
        n_vec++;
        if (sb.size() != 0 || s1_q.size() != 0 || s2_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d beats still expected after %0d cycles, required 0",
                     name, sb.size(), cyc);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] g, input logic v);
        n_vec++;
        if (sn_grant !== g || sn_rvalid_m !== v) begin
            n_err++;
            $display("FAIL %s: grant=%b rvalid_m=%b, required grant=%b rvalid_m=%b",
                     name, sn_grant, sn_rvalid_m, g, v);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s1_q.delete();
        s2_q.delete();
        sb.delete();
        apply_slaves();
        step();
        step();
        areset = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic test_reset();
        rready_m = 1'b1;
        do_reset();
        step();
        check_state("reset_state", 2'b00, 1'b0);
        n_vec++;
        if (sn_rready_s1 !== 1'b0 || sn_rready_s2 !== 1'b0 || sn_beat !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rready_s1=%b rready_s2=%b payload=%h, required 0 0 0",
                     sn_rready_s1, sn_rready_s2, sn_beat);
        end
    endtask

    // Single s1 burst at full rate: first beat one cycle after rvalid_s1 rises.
    task automatic test_basic_burst();
        rready_m = 1'b1;
        load_burst(1, 4'h3, 32'hA0, 4);
        sb_burst(4'h3, 32'hA0, 4);
        apply_slaves();
        for (int k = 0; k < 6; k++) begin
            step();
            check_state($sformatf("basic_cycle%0d", k),
                        (k >= 1 && k <= 4) ? 2'b01 : 2'b00, (k >= 1 && k <= 4));
        end
        drain("basic", 4);
    endtask

    // Round robin: s1 wins the first tie after reset, s2 wins a tie after s1 was served.
    task automatic test_tie();
        rready_m = 1'b1;
        do_reset();
        load_burst(1, 4'h1, 32'h100, 2);
        load_burst(2, 4'h2, 32'h200, 3);
        sb_burst(4'h1, 32'h100, 2);
        sb_burst(4'h2, 32'h200, 3);
        apply_slaves();
        step();
        step();
        check_state("tie1_first_owner", 2'b01, 1'b1);
        drain("tie1", 20);
        load_burst(1, 4'h5, 32'h500, 1);
        sb_burst(4'h5, 32'h500, 1);
        apply_slaves();
        drain("solo_s1", 10);
        step();
        load_burst(1, 4'h6, 32'h600, 2);
        load_burst(2, 4'h7, 32'h700, 2);
        sb_burst(4'h7, 32'h700, 2);
        sb_burst(4'h6, 32'h600, 2);
        apply_slaves();
        step();
        step();
        check_state("tie2_first_owner", 2'b10, 1'b1);
        drain("tie2", 20);
    endtask

    // s2 requests during an s1 burst: it is held off and starts after one idle cycle.
    task automatic test_back_to_back();
        int cyc = 0;
        rready_m = 1'b1;
        step();
        load_burst(1, 4'h3, 32'hB0, 4);
        sb_burst(4'h3, 32'hB0, 4);
        apply_slaves();
        step();
        step();
        load_burst(2, 4'h9, 32'hC0, 2);
        sb_burst(4'h9, 32'hC0, 2);
        apply_slaves();
        while (s1_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        n_vec++;
        if (!(sn_hsm === 1'b1 && sn_beat.last === 1'b1 && sn_grant === 2'b01)) begin
            n_err++;
            $display("FAIL b2b_s1_last: hs=%b rlast=%b grant=%b, required 1 1 01",
                     sn_hsm, sn_beat.last, sn_grant);
        end
        step();
        check_state("b2b_dead_cycle", 2'b00, 1'b0);
        step();
        check_state("b2b_s2_start", 2'b10, 1'b1);
        drain("b2b", 10);
    endtask

    // rready_m pattern 1,0,0,1 repeated: stalled payload must hold, no beats lost.
    task automatic test_stall();
        int k = 0;
        logic [3:0] pat = 4'b1001;
        step();
        load_burst(1, 4'hE, 32'hD0, 4);
        sb_burst(4'hE, 32'hD0, 4);
        apply_slaves();
        step();
        while ((sb.size() != 0 || s1_q.size() != 0) && k < 40) begin
            rready_m = pat[3 - (k % 4)];
            step();
            k++;
        end
        rready_m = 1'b1;
        drain("stall", 4);
    endtask

    // Reset while beat 2 of 4 is presented; the burst is abandoned.
    task automatic test_reset_mid_burst();
        rready_m = 1'b1;
        step();
        load_burst(1, 4'h4, 32'hE0, 4);
        sb_burst(4'h4, 32'hE0, 4);
        apply_slaves();
        step();
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        s1_q.delete();
        sb.delete();
        stall_prev = 1'b0;
        load_burst(1, 4'h8, 32'hF0, 2);
        sb_burst(4'h8, 32'hF0, 2);
        apply_slaves();
        step();
        check_state("rst_mid_after", 2'b00, 1'b0);
        n_vec++;
        if (sn_rready_s1 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_rready_s1: got %b, required 0", sn_rready_s1);
        end
        step();
        check_state("rst_mid_rearb", 2'b01, 1'b1);
        drain("rst_mid", 10);
    endtask

    initial begin
        apply_slaves();
        test_reset();
        test_basic_burst();
        test_tie();
        test_back_to_back();
        test_stall();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
